dmem_resp: RTL

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/riscv_pkg.sv | 66 ++++++
 rtl/dmem_sb.sv | 92 +++++++++
 rtl/dmem_resp.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared types and constants for the data-memory response block:
//            access-size encodings, store-buffer entry layout, store helpers.
// Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // One-hot access sizes as presented by the execute stage.
  localparam logic [2:0] SIZE_B = 3'b001;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_W = 3'b100;

  // One pending store: word address, byte enables, and data already in lanes.
  typedef struct packed {
    logic            valid;
    logic [XLEN-3:0] wadr;
    logic [3:0]      be;
    logic [XLEN-1:0] data;
  } sb_entry_t;

  // Natural alignment check; unknown size encodings count as misaligned.
  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = ~lo[0];
      SIZE_W:  ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Build a buffer entry with the store data replicated into its byte lanes.
  function automatic sb_entry_t make_entry(input logic [XLEN-1:0] adr,
                                           input logic [2:0]      size,
                                           input logic [XLEN-1:0] sdata);
    sb_entry_t e;
    e.valid = 1'b1;
    e.wadr  = adr[XLEN-1:2];
    e.be    = 4'b0000;
    e.data  = '0;
    case (size)
      SIZE_B: begin
        e.be   = 4'b0001 << adr[1:0];
        e.data = {4{sdata[7:0]}};
      end
      SIZE_H: begin
        e.be   = adr[1] ? 4'b1100 : 4'b0011;
        e.data = {2{sdata[15:0]}};
      end
      SIZE_W: begin
        e.be   = 4'b1111;
        e.data = sdata;
      end
      default: ;
    endcase
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_sb.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sb
// Brief    : Circular store buffer with per-byte youngest-match forwarding.
//            Head is the oldest entry and is presented for draining.
// Revision : 1.0  initial release
// ============================================================================
module dmem_sb
  import riscv_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  sb_entry_t        push_entry_i,
  input  logic             pop_i,
  output sb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  input  logic [XLEN-3:0]  lkp_wadr_i,
  output logic [3:0]       lkp_hit_o,
  output logic [XLEN-1:0]  lkp_data_o
);

  localparam int PW = $clog2(SB_DEPTH);

  sb_entry_t       ent_q [SB_DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic [PW-1:0]   idx;

  assign head_o  = ent_q[head_q];
  assign full_o  = (count_q == (PW+1)'(SB_DEPTH));
  assign empty_o = (count_q == '0);

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    if (push_i) tail_d = tail_q + PW'(1);
    if (pop_i)  head_d = head_q + PW'(1);
    count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
  end

  // Entry storage; a push into the slot being popped (full case) wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop_i) ent_q[head_q].valid <= 1'b0;
      if (push_i) begin
        ent_q[tail_q]       <= push_entry_i;
        ent_q[tail_q].valid <= 1'b1;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Forwarding: walk oldest to youngest so younger matching bytes override.
  always_comb begin
    lkp_hit_o  = '0;
    lkp_data_o = '0;
    idx        = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (ent_q[idx].valid && (ent_q[idx].wadr == lkp_wadr_i)) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_q[idx].be[b]) begin
            lkp_hit_o[b]         = 1'b1;
            lkp_data_o[8*b +: 8] = ent_q[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

  // Drain always wins when full, so a push never lands on a full buffer unpopped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push_i && full_o && !pop_i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp
// Brief    : Data RAM with a store buffer in front of its single write port.
//            Loads read combinationally with byte forwarding from the buffer;
//            the write port is shared between the loader and buffer drain.
// Revision : 1.0  initial release
// ============================================================================
module dmem_resp
  import riscv_pkg::*;
#(
  parameter int              DMEM_WORDS = 1024,
  parameter logic [XLEN-1:0] DMEM_BASE  = 32'h0000_0000,
  parameter int              SB_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            access_fault_o,
  input  logic            ldr_v_i,
  input  logic [XLEN-1:0] ldr_adr_i,
  input  logic [XLEN-1:0] ldr_data_i,
  output logic            ldr_ready_o,
  output logic            sb_empty_o
);

  localparam int              IDXW        = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [XLEN:0]   RANGE_BYTES = (XLEN+1)'(DMEM_WORDS) << 2;

  logic [XLEN-1:0] mem_q [DMEM_WORDS];

  // Offsets are one bit wider so addresses below the base wrap to huge values.
  logic [XLEN:0]   ld_off, ldr_off, dr_off;
  logic            ld_in_range, ldr_in_range;
  logic [IDXW-1:0] ld_idx, ldr_idx, dr_idx;

  logic            sb_push, sb_pop, sb_full, sb_empty;
  sb_entry_t       sb_head, push_entry;
  logic [3:0]      fwd_hit;
  logic [XLEN-1:0] fwd_data, ram_word;

  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [3:0]      wr_be;
  logic [XLEN-1:0] wr_data;
  logic            unused_bits;

  assign ld_off       = {1'b0, adr_i} - {1'b0, DMEM_BASE};
  assign ld_in_range  = (ld_off < RANGE_BYTES);
  assign ld_idx       = ld_off[IDXW+1:2];

  assign ldr_off      = {1'b0, ldr_adr_i} - {1'b0, DMEM_BASE};
  assign ldr_in_range = (ldr_off < RANGE_BYTES);
  assign ldr_idx      = ldr_off[IDXW+1:2];

  assign dr_off       = {1'b0, sb_head.wadr, 2'b00} - {1'b0, DMEM_BASE};
  assign dr_idx       = dr_off[IDXW+1:2];
  assign unused_bits  = ^{dr_off[XLEN:IDXW+2], dr_off[1:0], sb_head.valid};

  assign access_fault_o = adr_v_i & ~ld_in_range;
  assign sb_push        = adr_v_i & is_store_i & ld_in_range
                        & is_aligned(access_size_i, adr_i[1:0]);
  assign push_entry     = make_entry(adr_i, access_size_i, store_data_i);

  assign ldr_ready_o = ~sb_full;
  assign sb_empty_o  = sb_empty;

  dmem_sb #(
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .push_i       (sb_push),
    .push_entry_i (push_entry),
    .pop_i        (sb_pop),
    .head_o       (sb_head),
    .full_o       (sb_full),
    .empty_o      (sb_empty),
    .lkp_wadr_i   (adr_i[XLEN-1:2]),
    .lkp_hit_o    (fwd_hit),
    .lkp_data_o   (fwd_data)
  );

  // Write-port arbitration: full buffer drains first, then loader, then drain.
  always_comb begin
    sb_pop  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_be   = '0;
    wr_data = '0;
    if (sb_full) begin
      sb_pop  = 1'b1;
      wr_en   = 1'b1;
      wr_idx  = dr_idx;
      wr_be   = sb_head.be;
      wr_data = sb_head.data;
    end else if (ldr_v_i) begin
      wr_en   = ldr_in_range;
      wr_idx  = ldr_idx;
      wr_be   = 4'b1111;
      wr_data = ldr_data_i;
    end else if (!sb_empty) begin
      sb_pop  = 1'b1;
      wr_en   = 1'b1;
      wr_idx  = dr_idx;
      wr_be   = sb_head.be;
      wr_data = sb_head.data;
    end
  end

  // RAM byte-write port; contents persist across reset, writes suppressed under it.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Load path: per-lane merge of buffered bytes over RAM; out-of-range reads zero.
  always_comb begin
    ram_word    = mem_q[ld_idx];
    load_data_o = '0;
    if (ld_in_range) begin
      for (int b = 0; b < 4; b++) begin
        load_data_o[8*b +: 8] = fwd_hit[b] ? fwd_data[8*b +: 8] : ram_word[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire
